// File: rtl/sobel_pack_writer.sv
// sobel_pack_writer
//   Packs a stream of filtered pixel bytes into 64-bit SRAM words and writes
//   them to consecutive addresses starting at a latched base address.
//   Byte k of a word is placed at data[63-8k -: 8], so the first byte received
//   is the most significant. A flush pulse writes a partially filled word,
//   with its unfilled low bytes padded with zeros.
//
// Parameters
//   ROW_WORDS  64-bit words per image row; colPos counts modulo this value
//   ADDR_W     write address width
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   startEn    one-cycle start pulse; samples baseAddr and numWords
//   baseAddr   first word address
//   numWords   number of words to write (0 = none)
//   pixIn      filtered pixel byte
//   pixValid   pixIn valid
//   flush      one-cycle pulse: write the partial word now
//   pixReady   byte accepted when pixValid && pixReady
//   we         one-cycle SRAM write strobe
//   write_addr SRAM write address (holds between writes)
//   data       SRAM write data (holds between writes)
//   colPos     word column of write_addr within the row
//   busy       high while a job is in progress
//   done       one-cycle pulse when the job completes
module sobel_pack_writer #(
  parameter int ROW_WORDS = 256,
  parameter int ADDR_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startEn,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] numWords,
  input  logic [7:0]        pixIn,
  input  logic              pixValid,
  input  logic              flush,
  output logic              pixReady,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [63:0]       data,
  output logic [7:0]        colPos,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_LAST    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [7:0] COL_LAST = 8'(ROW_WORDS - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] num_words_q;
  logic [7:0]        cur_col;
  logic [2:0]        byte_idx;
  logic [63:0]       acc;

  logic              accept;
  logic              word_full;
  logic              flush_fire;
  logic              word_emit;
  logic [63:0]       word_next;

  assign pixReady = (state == S_COLLECT);
  assign busy     = (state == S_COLLECT) || (state == S_LAST);
  assign done     = (state == S_DONE);

  // Merge the incoming byte into the word being assembled. The accumulator is
  // kept zero in its unfilled lanes, so a flushed word is already padded.
  always_comb begin
    accept    = pixValid && pixReady;
    word_next = acc;
    if (accept) begin
      word_next[{~byte_idx, 3'b000} +: 8] = pixIn;
    end
    word_full  = accept && (byte_idx == 3'd7);
    // A flush with an empty word does nothing; a flush coinciding with the
    // eighth byte merges into that single full-word write.
    flush_fire = flush && (state == S_COLLECT) && (byte_idx != 3'd0);
    word_emit  = word_full || flush_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      we          <= 1'b0;
      write_addr  <= '0;
      data        <= '0;
      colPos      <= '0;
      cur_addr    <= '0;
      cur_col     <= '0;
      word_cnt    <= '0;
      num_words_q <= '0;
      byte_idx    <= '0;
      acc         <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (startEn) begin
            if (numWords != '0) begin
              state       <= S_COLLECT;
              cur_addr    <= baseAddr;
              num_words_q <= numWords;
              word_cnt    <= '0;
              cur_col     <= '0;
              byte_idx    <= '0;
              acc         <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_COLLECT: begin
          if (accept) begin
            byte_idx <= byte_idx + 3'd1;
            acc      <= word_next;
          end
          if (word_emit) begin
            we         <= 1'b1;
            data       <= word_next;
            write_addr <= cur_addr;
            colPos     <= cur_col;
            cur_addr   <= cur_addr + ADDR_W'(1);
            cur_col    <= (cur_col == COL_LAST) ? 8'd0 : cur_col + 8'd1;
            acc        <= '0;
            byte_idx   <= '0;
            word_cnt   <= word_cnt + ADDR_W'(1);
            // Stop accepting as soon as the final word is captured so the
            // byte offered in the write cycle is refused.
            if (word_cnt + ADDR_W'(1) == num_words_q) begin
              state <= S_LAST;
            end
          end
        end
        S_LAST: begin
          // The final write strobe is high on entry; move on once it drops.
          if (!we) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
